// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control path: state enum, opcodes,
// ALU/mux select codes and the bundled control-output record.
package multicycle_ctrl_pkg;

   typedef enum logic [3:0] {
      StIdle,
      StFetch,
      StDecode,
      StMemAddr,
      StMemRd,
      StMemWb,
      StMemWr,
      StRExec,
      StRWb,
      StBranch,
      StAddiExec,
      StAddiWb,
      StJump
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;

   localparam logic [1:0] SRCB_REG     = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic [1:0] alu_op;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_source;
      logic       pc_write;
      logic       pc_write_cond;
      logic       branch_ne;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       reg_write;
      logic       mem_to_reg;
      logic       instr_done;
      logic       illegal_op;
   } ctrl_t;

   function automatic logic is_legal_op(input logic [5:0] op);
      case (op)
         OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J: is_legal_op = 1'b1;
         default:                                              is_legal_op = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mc_ctrl_out_decode.sv
// Combinational decode of FSM state, opcode and memory handshake into datapath controls.
module mc_ctrl_out_decode
   import multicycle_ctrl_pkg::*;
(
   input  logic       i_rst_n,
   input  state_e     i_state,
   input  logic [5:0] i_opcode,
   input  logic       i_mem_ready,
   output ctrl_t      o_ctrl
);

   // Per-state control decode; reset low forces everything quiet so no write leaks out.
   always_comb begin
      o_ctrl = '0;
      case (i_state)
         StFetch: begin
            o_ctrl.mem_read  = 1'b1;
            o_ctrl.alu_src_b = SRCB_FOUR;
            o_ctrl.alu_op    = ALUOP_ADD;
            o_ctrl.pc_source = PCSRC_ALU;
            // IR load and PC+4 commit only in the cycle the fetch completes
            o_ctrl.ir_write  = i_mem_ready;
            o_ctrl.pc_write  = i_mem_ready;
         end
         StDecode: begin
            // branch target precomputed into ALUOut
            o_ctrl.alu_src_b  = SRCB_IMM_SH2;
            o_ctrl.alu_op     = ALUOP_ADD;
            o_ctrl.illegal_op = ~is_legal_op(i_opcode);
         end
         StMemAddr, StAddiExec: begin
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_src_b = SRCB_IMM;
            o_ctrl.alu_op    = ALUOP_ADD;
         end
         StMemRd: begin
            o_ctrl.mem_read = 1'b1;
            o_ctrl.i_or_d   = 1'b1;
         end
         StMemWb: begin
            o_ctrl.reg_write  = 1'b1;
            o_ctrl.mem_to_reg = 1'b1;
            o_ctrl.instr_done = 1'b1;
         end
         StMemWr: begin
            o_ctrl.mem_write  = 1'b1;
            o_ctrl.i_or_d     = 1'b1;
            o_ctrl.instr_done = i_mem_ready;
         end
         StRExec: begin
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_src_b = SRCB_REG;
            o_ctrl.alu_op    = ALUOP_RTYPE;
         end
         StRWb: begin
            o_ctrl.reg_write  = 1'b1;
            o_ctrl.reg_dst    = 1'b1;
            o_ctrl.instr_done = 1'b1;
         end
         StBranch: begin
            o_ctrl.alu_src_a     = 1'b1;
            o_ctrl.alu_src_b     = SRCB_REG;
            o_ctrl.alu_op        = ALUOP_SUB;
            o_ctrl.pc_write_cond = 1'b1;
            o_ctrl.pc_source     = PCSRC_ALUOUT;
            o_ctrl.branch_ne     = (i_opcode == OP_BNE);
            o_ctrl.instr_done    = 1'b1;
         end
         StAddiWb: begin
            o_ctrl.reg_write  = 1'b1;
            o_ctrl.instr_done = 1'b1;
         end
         StJump: begin
            o_ctrl.pc_write   = 1'b1;
            o_ctrl.pc_source  = PCSRC_JUMP;
            o_ctrl.instr_done = 1'b1;
         end
         default: ;
      endcase
      if (!i_rst_n) begin
         o_ctrl = '0;
      end
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main sequencer for the multi-cycle datapath: state register plus next-state logic;
// output decode lives in mc_ctrl_out_decode.
module multicycle_control_fsm
   import multicycle_ctrl_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [5:0] i_opcode,
   input  logic       i_mem_ready,
   output logic [1:0] o_alu_op,
   output logic       o_alu_src_a,
   output logic [1:0] o_alu_src_b,
   output logic [1:0] o_pc_source,
   output logic       o_pc_write,
   output logic       o_pc_write_cond,
   output logic       o_branch_ne,
   output logic       o_i_or_d,
   output logic       o_mem_read,
   output logic       o_mem_write,
   output logic       o_ir_write,
   output logic       o_reg_dst,
   output logic       o_reg_write,
   output logic       o_mem_to_reg,
   output logic       o_instr_done,
   output logic       o_illegal_op
);

   state_e r_state;
   ctrl_t  w_ctrl;

   // State register with synchronous reset and all transitions
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= StIdle;
      end else begin
         case (r_state)
            StIdle:  r_state <= StFetch;
            StFetch: if (i_mem_ready) r_state <= StDecode;
            StDecode: begin
               case (i_opcode)
                  OP_LW, OP_SW:   r_state <= StMemAddr;
                  OP_RTYPE:       r_state <= StRExec;
                  OP_BEQ, OP_BNE: r_state <= StBranch;
                  OP_ADDI:        r_state <= StAddiExec;
                  OP_J:           r_state <= StJump;
                  default:        r_state <= StFetch;
               endcase
            end
            StMemAddr: begin
               if (i_opcode == OP_LW) begin
                  r_state <= StMemRd;
               end else if (i_opcode == OP_SW) begin
                  r_state <= StMemWr;
               end else begin
                  r_state <= StFetch;
               end
            end
            StMemRd:    if (i_mem_ready) r_state <= StMemWb;
            StMemWb:    r_state <= StFetch;
            StMemWr:    if (i_mem_ready) r_state <= StFetch;
            StRExec:    r_state <= StRWb;
            StRWb:      r_state <= StFetch;
            StBranch:   r_state <= StFetch;
            StAddiExec: r_state <= StAddiWb;
            StAddiWb:   r_state <= StFetch;
            StJump:     r_state <= StFetch;
            default:    r_state <= StIdle;
         endcase
      end
   end

   mc_ctrl_out_decode u_out_decode (
      .i_rst_n     (i_rst_n),
      .i_state     (r_state),
      .i_opcode    (i_opcode),
      .i_mem_ready (i_mem_ready),
      .o_ctrl      (w_ctrl)
   );

   assign o_alu_op        = w_ctrl.alu_op;
   assign o_alu_src_a     = w_ctrl.alu_src_a;
   assign o_alu_src_b     = w_ctrl.alu_src_b;
   assign o_pc_source     = w_ctrl.pc_source;
   assign o_pc_write      = w_ctrl.pc_write;
   assign o_pc_write_cond = w_ctrl.pc_write_cond;
   assign o_branch_ne     = w_ctrl.branch_ne;
   assign o_i_or_d        = w_ctrl.i_or_d;
   assign o_mem_read      = w_ctrl.mem_read;
   assign o_mem_write     = w_ctrl.mem_write;
   assign o_ir_write      = w_ctrl.ir_write;
   assign o_reg_dst       = w_ctrl.reg_dst;
   assign o_reg_write     = w_ctrl.reg_write;
   assign o_mem_to_reg    = w_ctrl.mem_to_reg;
   assign o_instr_done    = w_ctrl.instr_done;
   assign o_illegal_op    = w_ctrl.illegal_op;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench: directed vector table for the corner cases, then random
// instruction streams checked against a per-instruction script model.
module tb_multicycle_control_fsm;

   localparam int unsigned NumRandInstr = 300;

   localparam bit [5:0] C_R    = 6'b000000;
   localparam bit [5:0] C_LW   = 6'b100011;
   localparam bit [5:0] C_SW   = 6'b101011;
   localparam bit [5:0] C_BEQ  = 6'b000100;
   localparam bit [5:0] C_BNE  = 6'b000101;
   localparam bit [5:0] C_ADDI = 6'b001000;
   localparam bit [5:0] C_J    = 6'b000010;
   localparam bit [5:0] C_BAD  = 6'b111111;

   // Output vector: {alu_op, src_a, src_b, pc_source, 12 single-bit flags}
   localparam bit [18:0] PCW  = 19'h00800;
   localparam bit [18:0] PCWC = 19'h00400;
   localparam bit [18:0] BNE  = 19'h00200;
   localparam bit [18:0] IORD = 19'h00100;
   localparam bit [18:0] MRD  = 19'h00080;
   localparam bit [18:0] MWR  = 19'h00040;
   localparam bit [18:0] IRW  = 19'h00020;
   localparam bit [18:0] RDST = 19'h00010;
   localparam bit [18:0] RW   = 19'h00008;
   localparam bit [18:0] M2R  = 19'h00004;
   localparam bit [18:0] DONE = 19'h00002;
   localparam bit [18:0] ILL  = 19'h00001;

   localparam bit [18:0] E_FETCH = {2'b00, 1'b0, 2'b01, 2'b00, 12'h000} | MRD;
   localparam bit [18:0] E_FGO   = E_FETCH | IRW | PCW;
   localparam bit [18:0] E_DEC   = {2'b00, 1'b0, 2'b11, 2'b00, 12'h000};
   localparam bit [18:0] E_MADDR = {2'b00, 1'b1, 2'b10, 2'b00, 12'h000};
   localparam bit [18:0] E_MRD   = MRD | IORD;
   localparam bit [18:0] E_MWB   = RW | M2R | DONE;
   localparam bit [18:0] E_MWR   = MWR | IORD;
   localparam bit [18:0] E_REXE  = {2'b10, 1'b1, 2'b00, 2'b00, 12'h000};
   localparam bit [18:0] E_RWB   = RW | RDST | DONE;
   localparam bit [18:0] E_BR    = {2'b01, 1'b1, 2'b00, 2'b01, 12'h000} | PCWC | DONE;
   localparam bit [18:0] E_AEXE  = {2'b00, 1'b1, 2'b10, 2'b00, 12'h000};
   localparam bit [18:0] E_AWB   = RW | DONE;
   localparam bit [18:0] E_J     = {2'b00, 1'b0, 2'b00, 2'b10, 12'h000} | PCW | DONE;

   typedef struct {
      string    name;
      bit       rst_n;
      bit       mem_ready;
      bit [5:0] op;
      bit [18:0] exp;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic [5:0]  opcode;
   logic        mem_ready;
   logic [1:0]  alu_op;
   logic        alu_src_a;
   logic [1:0]  alu_src_b;
   logic [1:0]  pc_source;
   logic        pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write;
   logic        ir_write, reg_dst, reg_write, mem_to_reg, instr_done, illegal_op;
   logic [18:0] act;

   vec_t        tbl[$];
   vec_t        ins[$];
   int unsigned n_vec;
   int unsigned n_bad;

   multicycle_control_fsm dut (
      .i_clk           (clk),
      .i_rst_n         (rst_n),
      .i_opcode        (opcode),
      .i_mem_ready     (mem_ready),
      .o_alu_op        (alu_op),
      .o_alu_src_a     (alu_src_a),
      .o_alu_src_b     (alu_src_b),
      .o_pc_source     (pc_source),
      .o_pc_write      (pc_write),
      .o_pc_write_cond (pc_write_cond),
      .o_branch_ne     (branch_ne),
      .o_i_or_d        (i_or_d),
      .o_mem_read      (mem_read),
      .o_mem_write     (mem_write),
      .o_ir_write      (ir_write),
      .o_reg_dst       (reg_dst),
      .o_reg_write     (reg_write),
      .o_mem_to_reg    (mem_to_reg),
      .o_instr_done    (instr_done),
      .o_illegal_op    (illegal_op)
   );

   assign act = {alu_op, alu_src_a, alu_src_b, pc_source, pc_write, pc_write_cond, branch_ne,
                 i_or_d, mem_read, mem_write, ir_write, reg_dst, reg_write, mem_to_reg,
                 instr_done, illegal_op};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic bit rnd_bit();
      return 1'($urandom_range(1, 0));
   endfunction

   function automatic void add(input string name, input bit rn, input bit mr, input bit [5:0] op,
                               input bit [18:0] exp);
      vec_t v;
      v.name = name; v.rst_n = rn; v.mem_ready = mr; v.op = op; v.exp = exp;
      tbl.push_back(v);
   endfunction

   function automatic void put(input bit mr, input bit [5:0] op, input bit [18:0] exp);
      vec_t v;
      v.name = "rand"; v.rst_n = 1'b1; v.mem_ready = mr; v.op = op; v.exp = exp;
      ins.push_back(v);
   endfunction

   // Reference script: the cycle-by-cycle outputs one instruction must produce, given
   // how many cycles each memory access is made to wait.
   function automatic void gen_instr(input bit [5:0] op, input int fst, input int mst);
      bit legal;
      legal = (op == C_R) || (op == C_LW) || (op == C_SW) || (op == C_BEQ) ||
              (op == C_BNE) || (op == C_ADDI) || (op == C_J);
      ins.delete();
      for (int i = 0; i < fst; i++) put(1'b0, op, E_FETCH);
      put(1'b1, op, E_FGO);
      put(rnd_bit(), op, legal ? E_DEC : (E_DEC | ILL));
      if (op == C_LW) begin
         put(rnd_bit(), op, E_MADDR);
         for (int i = 0; i < mst; i++) put(1'b0, op, E_MRD);
         put(1'b1, op, E_MRD);
         put(rnd_bit(), op, E_MWB);
      end else if (op == C_SW) begin
         put(rnd_bit(), op, E_MADDR);
         for (int i = 0; i < mst; i++) put(1'b0, op, E_MWR);
         put(1'b1, op, E_MWR | DONE);
      end else if (op == C_R) begin
         put(rnd_bit(), op, E_REXE);
         put(rnd_bit(), op, E_RWB);
      end else if (op == C_BEQ || op == C_BNE) begin
         put(rnd_bit(), op, (op == C_BNE) ? (E_BR | BNE) : E_BR);
      end else if (op == C_ADDI) begin
         put(rnd_bit(), op, E_AEXE);
         put(rnd_bit(), op, E_AWB);
      end else if (op == C_J) begin
         put(rnd_bit(), op, E_J);
      end
   endfunction

   task automatic apply(input vec_t v, input int idx);
      rst_n = v.rst_n;
      mem_ready = v.mem_ready;
      opcode = v.op;
      @(negedge clk);
      n_vec++;
      if (act !== v.exp) begin
         n_bad++;
         $display("FAIL %s (vector %0d): got %05h, required %05h", v.name, idx, act, v.exp);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit [5:0] legal_ops [7];
      bit [5:0] op;
      int       cut;
      legal_ops = '{C_R, C_LW, C_SW, C_BEQ, C_BNE, C_ADDI, C_J};
      n_vec = 0;
      n_bad = 0;
      rst_n = 1'b0;
      mem_ready = 1'b0;
      opcode = 6'd0;

      // Directed table
      add("reset0", 0, 1, C_R, '0);
      add("reset1", 0, 0, C_R, '0);
      add("idle", 1, 1, C_R, '0);
      add("r_fetch", 1, 1, C_R, E_FGO);
      add("r_dec", 1, 0, C_R, E_DEC);
      add("r_exec", 1, 1, C_R, E_REXE);
      add("r_wb", 1, 0, C_R, E_RWB);
      add("lw_fwait1", 1, 0, C_LW, E_FETCH);
      add("lw_fwait2", 1, 0, C_LW, E_FETCH);
      add("lw_fetch", 1, 1, C_LW, E_FGO);
      add("lw_dec", 1, 1, C_LW, E_DEC);
      add("lw_addr", 1, 1, C_LW, E_MADDR);
      add("lw_rwait", 1, 0, C_LW, E_MRD);
      add("lw_rd", 1, 1, C_LW, E_MRD);
      add("lw_wb", 1, 1, C_LW, E_MWB);
      add("bne_fetch", 1, 1, C_BNE, E_FGO);
      add("bne_dec", 1, 1, C_BNE, E_DEC);
      add("bne_br", 1, 1, C_BNE, E_BR | BNE);
      add("beq_fetch", 1, 1, C_BEQ, E_FGO);
      add("beq_dec", 1, 0, C_BEQ, E_DEC);
      add("beq_br", 1, 0, C_BEQ, E_BR);
      add("sw_fetch", 1, 1, C_SW, E_FGO);
      add("sw_dec", 1, 1, C_SW, E_DEC);
      add("sw_addr", 1, 1, C_SW, E_MADDR);
      add("sw_wwait1", 1, 0, C_SW, E_MWR);
      add("sw_wwait2", 1, 0, C_SW, E_MWR);
      add("sw_wr", 1, 1, C_SW, E_MWR | DONE);
      add("ill_fetch", 1, 1, C_BAD, E_FGO);
      add("ill_dec", 1, 1, C_BAD, E_DEC | ILL);
      add("addi_fetch", 1, 1, C_ADDI, E_FGO);
      add("addi_dec", 1, 1, C_ADDI, E_DEC);
      add("addi_exec", 1, 1, C_ADDI, E_AEXE);
      add("addi_wb", 1, 1, C_ADDI, E_AWB);
      add("j_fetch", 1, 1, C_J, E_FGO);
      add("j_dec", 1, 1, C_J, E_DEC);
      add("j_jump", 1, 1, C_J, E_J);
      add("rst_rd_fetch", 1, 1, C_LW, E_FGO);
      add("rst_rd_dec", 1, 1, C_LW, E_DEC);
      add("rst_rd_addr", 1, 1, C_LW, E_MADDR);
      add("rst_rd_wait", 1, 0, C_LW, E_MRD);
      add("rst_rd_rst", 0, 0, C_LW, '0);
      add("rst_rd_idle", 1, 0, C_LW, '0);
      add("rst_rd_refetch", 1, 0, C_LW, E_FETCH);
      add("rst_rd_fetch2", 1, 1, C_LW, E_FGO);
      add("rst_rd_dec2", 1, 1, C_LW, E_DEC);
      add("rst_rd_addr2", 1, 1, C_LW, E_MADDR);
      add("rst_rd_rd2", 1, 1, C_LW, E_MRD);
      add("rst_rd_wb2", 1, 1, C_LW, E_MWB);
      add("rst_wr_fetch", 1, 1, C_SW, E_FGO);
      add("rst_wr_dec", 1, 1, C_SW, E_DEC);
      add("rst_wr_addr", 1, 1, C_SW, E_MADDR);
      add("rst_wr_wait", 1, 0, C_SW, E_MWR);
      add("rst_wr_rst", 0, 1, C_SW, '0);
      add("rst_wr_idle", 1, 1, C_SW, '0);

      // Random instruction stream, occasionally cut short by a reset
      for (int n = 0; n < NumRandInstr; n++) begin
         int sel;
         sel = int'($urandom_range(7, 0));
         op = (sel < 7) ? legal_ops[sel] : 6'($urandom_range(63, 0));
         gen_instr(op, (rnd_bit() ? 0 : int'($urandom_range(3, 1))),
                   (rnd_bit() ? 0 : int'($urandom_range(3, 1))));
         cut = ($urandom_range(7, 0) == 0) ? int'($urandom_range(ins.size() - 1, 1))
                                           : ins.size();
         for (int i = 0; i < cut; i++) tbl.push_back(ins[i]);
         if (cut < ins.size()) begin
            add("rand_rst", 0, rnd_bit(), op, '0);
            add("rand_idle", 1, rnd_bit(), op, '0);
         end
      end

      @(posedge clk);
      #1;
      for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Main control state machine for the multi-cycle MIPS-subset datapath. It sequences each instruction through fetch, decode, execute, memory and writeback. It is the producer of the 2-bit `alu_op` code that the ALU control PLA consumes, alongside `inst[5:0]` (funct). It also drives every datapath enable and mux select, and stalls on a memory ready handshake.

## Interface
- No parameters; encodings are fixed in the package.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `opcode`  in  6  IR[31:26]; valid from DECODE onward.
- `mem_ready`  in  1  memory completes the current read/write this cycle.
- `alu_op`  out  2  00 add, 01 subtract/compare, 10 R-type (funct decides); 11 is never driven.
- `alu_src_a`  out  1  0 = PC, 1 = register A.
- `alu_src_b`  out  2  00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `pc_source`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- `pc_write`, `pc_write_cond`, `branch_ne`  out  1  PC update controls; `branch_ne` inverts the zero flag.
- `i_or_d`, `mem_read`, `mem_write`, `ir_write`  out  1  memory and IR controls.
- `reg_dst`, `reg_write`, `mem_to_reg`  out  1  register-file controls.
- `instr_done`  out  1  one-cycle pulse in the final cycle of each instruction.
- `illegal_op`  out  1  one-cycle pulse when an unsupported opcode is decoded.

## Operation
- States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, BRANCH, ADDI_EXEC, ADDI_WB, JUMP.
- Supported opcodes:
  - 000000 R-type
  - 100011 lw
  - 101011 sw
  - 000100 beq
  - 000101 bne
  - 001000 addi
  - 000010 j
- IDLE:
  - All outputs are 0.
  - Goes to FETCH unconditionally.
- FETCH:
  - Drives mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - Holds while mem_ready=0.
  - In the cycle mem_ready=1: ir_write=1, pc_write=1, next state DECODE. These two are Mealy outputs.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=11, alu_op=00 (branch target computed into ALUOut).
  - Next state by opcode:
    - lw/sw → MEM_ADDR
    - R → R_EXEC
    - beq/bne → BRANCH
    - addi → ADDI_EXEC
    - j → JUMP
    - anything else → FETCH with illegal_op=1. No register or memory write occurs.
- MEM_ADDR:
  - Drives alu_src_a=1, alu_src_b=10, alu_op=00.
  - lw → MEM_RD; sw → MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1; holds until mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1; then FETCH.
- MEM_WR: mem_write=1, i_or_d=1; holds until mem_ready. In the mem_ready cycle, instr_done=1; then FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; then R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1; then FETCH.
- BRANCH:
  - Drives alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1.
  - branch_ne=1 for bne, 0 for beq.
  - Then FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00; then ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1; then FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1; then FETCH.
- Any output not listed for a state is 0.
- Memory handshake:
  - mem_read/mem_write stay asserted, with stable i_or_d, for every cycle until mem_ready is sampled high.
  - mem_ready is ignored in all other states.

## Timing
- Reset:
  - rst_n=0 at a rising edge sets the state to IDLE, regardless of the current state, including mid-wait in FETCH/MEM_RD/MEM_WR.
  - All outputs are 0 from that edge until the first FETCH.
  - No write enable may assert in the cycle in which rst_n is low.
- Latency with mem_ready tied high: R = 4, lw = 5, sw = 4, beq/bne = 3, addi = 4, j = 3 cycles, counted from FETCH entry to the last cycle.
- Each memory wait cycle adds exactly 1 cycle.
- First FETCH occurs 2 cycles after rst_n rises: IDLE, then FETCH.
- instr_done is high in exactly one cycle per instruction.
- instr_done and illegal_op are never high in the same cycle.

## Structure
- Package `multicycle_ctrl_pkg` holds:
  - State enum.
  - Opcode constants.
  - `alu_op` constants: ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_RTYPE=10.
  - `alu_src_b` / `pc_source` select constants.
- Optional sub-module `mc_ctrl_out_decode`: purely combinational decode of state, opcode and mem_ready to outputs. The FSM top keeps only the state register and next-state logic.

## Test plan
- Reset mid-MEM_RD wait (mem_ready=0):
  - With rst_n=0, next cycle state is IDLE and all outputs are 0.
  - After release, FETCH with mem_read=1 follows 2 cycles later.
- R-type (opcode 000000), mem_ready=1:
  - alu_op sequence 00, 00, 10, 00 over 4 cycles.
  - reg_write=1 and reg_dst=1 only in cycle 4, together with instr_done.
- lw with fetch stalled 2 cycles and MEM_RD stalled 1 cycle:
  - Total 8 cycles.
  - ir_write pulses once, in cycle 3.
  - mem_to_reg=1 only in the final cycle.
- bne (000101):
  - BRANCH cycle drives alu_op=01, pc_write_cond=1, branch_ne=1, pc_source=01.
  - beq gives the same except branch_ne=0.
- sw (101011): mem_write is held until mem_ready; reg_write is never asserted.
- Illegal opcode 111111: illegal_op pulses in DECODE, next state is FETCH, no write enable asserts, instr_done stays 0.
